// File: rtl/sprite_pkg.sv
// Shared constants for the cloud sprite ROM and the arbiter that feeds it.
// Geometry, palette format, arbiter defaults and a pointer-width helper.
package sprite_pkg;

    localparam int CLOUD_W     = 128;
    localparam int CLOUD_H     = 71;
    localparam int CLOUD_DEPTH = CLOUD_W * CLOUD_H;

    localparam int ROM_AW = 14;
    localparam int PAL_DW = 4;

    localparam logic [PAL_DW-1:0] PAL_TRANSPARENT = 4'h0;

    localparam int ARB_N_REQ   = 4;
    localparam int ARB_ROM_LAT = 1;

    // A one-requester arbiter still needs a 1-bit pointer to stay legal.
    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin priority picker: first set req bit at or above ptr, wrapping.
// Ports: req (N), ptr (PW) in; gnt (N, one-hot or zero) out, combinational.
module rr_arbiter
    import sprite_pkg::*;
#(
    parameter int N  = ARB_N_REQ,
    parameter int PW = ptr_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt
);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [N-1:0]   first;
    logic [2*N-1:0] back;

    // Rotate so ptr sits at bit 0, isolate the lowest set bit, rotate back.
    always_comb begin
        dbl   = {req, req} >> ptr;
        rot   = dbl[N-1:0];
        first = rot & (~rot + 1'b1);
        back  = {first, first} << ptr;
        gnt   = back[2*N-1:N];
    end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Shares one registered-read sprite ROM among N_REQ requesters, round-robin.
// Ports: Clk, Reset_n; req/req_addr in; gnt, rom_addr out; rom_data in;
// rsp_valid (one-hot tag), rsp_data, rsp_oor out, ROM_LAT cycles after gnt.
module sprite_rom_arbiter
    import sprite_pkg::*;
#(
    parameter int N_REQ   = ARB_N_REQ,
    parameter int AW      = ROM_AW,
    parameter int DW      = PAL_DW,
    parameter int DEPTH   = CLOUD_DEPTH,
    parameter int ROM_LAT = ARB_ROM_LAT
) (
    input  logic                Clk,
    input  logic                Reset_n,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ*AW-1:0] req_addr,
    output logic [N_REQ-1:0]    gnt,
    output logic [AW-1:0]       rom_addr,
    input  logic [DW-1:0]       rom_data,
    output logic [N_REQ-1:0]    rsp_valid,
    output logic [DW-1:0]       rsp_data,
    output logic                rsp_oor
);

    localparam int PW = ptr_w(N_REQ);

    localparam logic [PW-1:0] LAST    = PW'(N_REQ - 1);
    localparam logic [AW:0]   DEPTH_W = (AW + 1)'(DEPTH);

    logic [PW-1:0]    ptr_q;
    logic [N_REQ-1:0] arb_gnt;
    logic [PW-1:0]    win;
    logic [AW-1:0]    sel_addr;
    logic             any_gnt;
    logic             oor;

    logic [N_REQ-1:0]   tag_q [ROM_LAT];
    logic [ROM_LAT-1:0] oor_q;

    rr_arbiter #(
        .N  (N_REQ),
        .PW (PW)
    ) u_rr (
        .req (req),
        .ptr (ptr_q),
        .gnt (arb_gnt)
    );

    // No grants may leave while reset is held.
    assign gnt     = Reset_n ? arb_gnt : '0;
    assign any_gnt = |gnt;

    always_comb begin
        win      = '0;
        sel_addr = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
                win      = i[PW-1:0];
                sel_addr = req_addr[i*AW +: AW];
            end
        end
    end

    assign oor      = any_gnt && ({1'b0, sel_addr} >= DEPTH_W);
    assign rom_addr = (any_gnt && !oor) ? sel_addr : '0;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            ptr_q <= '0;
        end else if (any_gnt) begin
            ptr_q <= (win == LAST) ? '0 : win + 1'b1;
        end
    end

    // Tags travel alongside the ROM's own read latency.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < ROM_LAT; i++) tag_q[i] <= '0;
            oor_q <= '0;
        end else begin
            tag_q[0] <= gnt;
            oor_q[0] <= oor;
            for (int i = 1; i < ROM_LAT; i++) begin
                tag_q[i] <= tag_q[i-1];
                oor_q[i] <= oor_q[i-1];
            end
        end
    end

    assign rsp_valid = tag_q[ROM_LAT-1];
    assign rsp_oor   = oor_q[ROM_LAT-1];

    // Out-of-range and idle cycles return the transparent index.
    assign rsp_data = (|rsp_valid && !rsp_oor) ? rom_data : PAL_TRANSPARENT;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed bench for sprite_rom_arbiter with ROM_LAT=1 and ROM_LAT=3 builds.
// Both instances share stimulus; each has its own registered ROM model.
module tb_sprite_rom_arbiter;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic [3:0]  req;
    logic [55:0] req_addr;

    logic [3:0]  g1, v1, g3, v3;
    logic [13:0] ra1, ra3;
    logic [3:0]  rd1, rd3, d1, d3;
    logic        o1, o3;
    logic [3:0]  r3a, r3b;

    int passed = 0;
    int fails  = 0;
    int total  = 0;

    always #5 Clk = ~Clk;

    sprite_rom_arbiter #(.ROM_LAT(1)) dut1 (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .req       (req),
        .req_addr  (req_addr),
        .gnt       (g1),
        .rom_addr  (ra1),
        .rom_data  (rd1),
        .rsp_valid (v1),
        .rsp_data  (d1),
        .rsp_oor   (o1)
    );

    sprite_rom_arbiter #(.ROM_LAT(3)) dut3 (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .req       (req),
        .req_addr  (req_addr),
        .gnt       (g3),
        .rom_addr  (ra3),
        .rom_data  (rd3),
        .rsp_valid (v3),
        .rsp_data  (d3),
        .rsp_oor   (o3)
    );

    function automatic logic [3:0] rom_f(input logic [13:0] a);
        logic [13:0] t;
        t = a * 14'd7 + 14'd3;
        return t[3:0];
    endfunction

    function automatic logic [13:0] oh2idx(input logic [3:0] oh);
        logic [13:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) if (oh[i]) r = 14'(i);
        return r;
    endfunction

    always @(posedge Clk) begin
        rd1 <= rom_f(ra1);
        r3a <= rom_f(ra3);
        r3b <= r3a;
        rd3 <= r3b;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic rn, input logic [3:0] r,
                       input logic [13:0] a0, input logic [13:0] a1,
                       input logic [13:0] a2, input logic [13:0] a3);
        @(posedge Clk);
        #1;
        Reset_n  = rn;
        req      = r;
        req_addr = {a3, a2, a1, a0};
        #3;
    endtask

    logic [3:0] gx [8];
    logic [3:0] ev;

    initial begin
        gx = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h0, 4'h0, 4'h0};
        Reset_n  = 1'b0;
        req      = 4'hF;
        req_addr = '0;
        #4;
        chk("rst_gnt", 32'(g1), 32'h0);
        chk("rst_valid", 32'(v1), 32'h0);
        chk("rst_data", 32'(d1), 32'h0);
        chk("rst_oor", 32'(o1), 32'h0);
        chk("rst_valid3", 32'(v3), 32'h0);

        // All four requesting, addresses equal to requester index.
        for (int k = 0; k < 8; k++) begin
            cyc(1'b1, (k < 5) ? 4'hF : 4'h0, 14'd0, 14'd1, 14'd2, 14'd3);
            chk($sformatf("rr_gnt%0d", k), 32'(g1), 32'(gx[k]));
            chk($sformatf("rr_gnt3_%0d", k), 32'(g3), 32'(gx[k]));
            chk($sformatf("rr_addr%0d", k), 32'(ra1), 32'(oh2idx(gx[k])));
            if (k >= 1) begin
                ev = gx[k-1];
                chk($sformatf("rr_v1_%0d", k), 32'(v1), 32'(ev));
                chk($sformatf("rr_d1_%0d", k), 32'(d1),
                    32'((ev != 0) ? rom_f(oh2idx(ev)) : 4'h0));
            end
            if (k >= 3) begin
                ev = gx[k-3];
                chk($sformatf("rr_v3_%0d", k), 32'(v3), 32'(ev));
                chk($sformatf("rr_d3_%0d", k), 32'(d3),
                    32'((ev != 0) ? rom_f(oh2idx(ev)) : 4'h0));
            end
        end

        // Single request, pointer at 1 wraps to requester 0.
        cyc(1'b1, 4'b0001, 14'd130, 14'd0, 14'd0, 14'd0);
        chk("single_gnt", 32'(g1), 32'h1);
        chk("single_addr", 32'(ra1), 32'd130);
        cyc(1'b1, 4'b0000, 14'd0, 14'd0, 14'd0, 14'd0);
        chk("single_gnt_idle", 32'(g1), 32'h0);
        chk("single_valid", 32'(v1), 32'h1);
        chk("single_data", 32'(d1), 32'(rom_f(14'd130)));
        chk("single_oor", 32'(o1), 32'h0);

        // Out of range: first and last addresses past the sprite.
        cyc(1'b1, 4'b0100, 14'd0, 14'd0, 14'd9088, 14'd0);
        chk("oor1_gnt", 32'(g1), 32'h4);
        chk("oor1_addr", 32'(ra1), 32'h0);
        cyc(1'b1, 4'b0100, 14'd0, 14'd0, 14'd16383, 14'd0);
        chk("oor2_gnt", 32'(g1), 32'h4);
        chk("oor2_addr", 32'(ra1), 32'h0);
        chk("oor1_valid", 32'(v1), 32'h4);
        chk("oor1_data", 32'(d1), 32'h0);
        chk("oor1_flag", 32'(o1), 32'h1);
        cyc(1'b1, 4'b0000, 14'd0, 14'd0, 14'd0, 14'd0);
        chk("oor2_valid", 32'(v1), 32'h4);
        chk("oor2_data", 32'(d1), 32'h0);
        chk("oor2_flag", 32'(o1), 32'h1);

        // Wrap fairness from ptr=3, with last in-range address.
        cyc(1'b1, 4'b1001, 14'd5, 14'd0, 14'd0, 14'd9087);
        chk("wrap_gnt_a", 32'(g1), 32'h8);
        chk("wrap_addr_a", 32'(ra1), 32'd9087);
        cyc(1'b1, 4'b1001, 14'd5, 14'd0, 14'd0, 14'd9087);
        chk("wrap_gnt_b", 32'(g1), 32'h1);
        chk("wrap_addr_b", 32'(ra1), 32'd5);
        chk("wrap_valid_a", 32'(v1), 32'h8);
        chk("wrap_data_a", 32'(d1), 32'(rom_f(14'd9087)));
        chk("wrap_oor_a", 32'(o1), 32'h0);
        cyc(1'b1, 4'b1001, 14'd5, 14'd0, 14'd0, 14'd9087);
        chk("wrap_gnt_c", 32'(g1), 32'h8);
        chk("wrap_valid_b", 32'(v1), 32'h1);
        chk("wrap_data_b", 32'(d1), 32'(rom_f(14'd5)));

        // Reset one cycle after a grant discards the in-flight read.
        cyc(1'b1, 4'b0010, 14'd0, 14'd77, 14'd0, 14'd0);
        chk("mid_gnt", 32'(g1), 32'h2);
        chk("mid_gnt3", 32'(g3), 32'h2);
        cyc(1'b0, 4'b0010, 14'd0, 14'd77, 14'd0, 14'd0);
        chk("mid_rst_gnt", 32'(g1), 32'h0);
        chk("mid_rst_v1", 32'(v1), 32'h0);
        chk("mid_rst_v3", 32'(v3), 32'h0);
        for (int k = 0; k < 3; k++) begin
            cyc(1'b1, 4'b0000, 14'd0, 14'd0, 14'd0, 14'd0);
            chk($sformatf("mid_post_v3_%0d", k), 32'(v3), 32'h0);
            chk($sformatf("mid_post_v1_%0d", k), 32'(v1), 32'h0);
        end
        cyc(1'b1, 4'hF, 14'd0, 14'd1, 14'd2, 14'd3);
        chk("mid_first_gnt", 32'(g1), 32'h1);
        chk("mid_first_gnt3", 32'(g3), 32'h1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
